wb_snoop_responder: RTL and testbench
=====================================

# wb_snoop_responder

Cache-side end of the snoop bus driven by `wb_snoop_arbiter`. One instance sits next to each data cache. It accepts a snoop read request (`snoop_adr_i`, `snoop_type_i`) and borrows the cache's tag/data read port through a request/grant handshake. It then returns ack, hit and the snooped word on `snoop_ack_o`, `snoop_hit_o` and `snoop_dat_o`, holding them until the arbiter withdraws the request.

## Interface
- `dw`, 32, data width.
- `aw`, 32, address width.
- `index_bits`, 8, cache set index width; index = `adr[offset_bits+index_bits-1:offset_bits]`.
- `offset_bits`, 4, line offset width; word select = `adr[offset_bits-1:2]`.
- Tag width `tw` = `aw-index_bits-offset_bits`; tag = `adr[aw-1:aw-tw]`.
- Clock and reset: one clock; reset is synchronous and active-low.
- `wb_clk_i` in 1: clock.
- `wb_rst_ni` in 1: synchronous active-low reset.
- `snoop_adr_i` in aw: snooped address.
- `snoop_type_i` in 1: 1 = READ, 0 = IDLE.
- `snoop_en_i` in 1: cache enabled; sampled when a request is accepted.
- `snoop_ack_o` out 1: response valid.
- `snoop_hit_o` out 1: line present (valid and tag match).
- `snoop_dat_o` out dw: snooped word; 0 when not hit.
- `snp_req_o` out 1: request for the cache tag/data read port.
- `snp_gnt_i` in 1: port granted this cycle; ignored while `snp_req_o`=0.
- `snp_idx_o` out index_bits: set index of the latched address.
- `snp_word_o` out offset_bits-2: word select of the latched address.
- `tag_i` in tw: tag read data; 1-cycle latency after grant.
- `valid_i` in 1: valid bit read data; same timing as `tag_i`.
- `dat_i` in dw: data word read data; same timing as `tag_i`.

## Operation
- State machine states:
  - IDLE: waits for a request.
  - REQ: `snp_req_o`=1, waiting for grant.
  - WAIT: RAM read cycle.
  - DONE: response held.
- Address latch `adr_q` is loaded on acceptance and on restart. `snp_idx_o` and `snp_word_o` decode from `adr_q` combinationally.
- IDLE, `snoop_type_i`=1:
  - `snoop_en_i`=1: latch address, go to REQ.
  - `snoop_en_i`=0: go straight to DONE with ack=1, hit=0, dat=0 (fast miss; no RAM access).
- REQ:
  - `snoop_type_i`=0: go to IDLE; `snp_req_o` drops next cycle.
  - Else if `snp_gnt_i`=1: go to WAIT.
  - Else stay in REQ; no timeout.
- WAIT:
  - Compute hit = `valid_i` && (`tag_i` == `adr_q` tag).
  - Register ack=1, hit, and dat (= `dat_i` if hit, else 0); go to DONE.
  - If `snoop_type_i`=0 in WAIT: discard the RAM data, go to IDLE, leave outputs 0.
- DONE: hold ack, hit and dat stable.
  - `snoop_type_i`=0: go to IDLE; clear all outputs at the same edge.
  - `snoop_adr_i` != `adr_q` while type=1: clear outputs, re-latch address, go to REQ (restart).
- Address change while in REQ or WAIT with type=1: re-latch and go to REQ. Any in-flight RAM data is discarded.
- `snp_req_o`=1 only in REQ. It is a registered function of the next state.
- No write snoops: `snoop_type_i`=0 never produces an ack.

## Timing
- Reset values: `snoop_ack_o`=0, `snoop_hit_o`=0, `snoop_dat_o`=0, `snp_req_o`=0, state IDLE, `adr_q`=0.
- Reset asserted mid-operation: back to IDLE at that edge; a pending grant or returning RAM data is ignored.
- Latency with immediate grant: ack goes high 3 edges after the first edge that samples type=1 (IDLE→REQ, REQ→WAIT, WAIT→DONE). Each stalled grant cycle adds 1.
- Fast-miss latency: 1 edge.
- Withdrawal: ack falls 1 edge after type is sampled 0.
- Back-to-back requests:
  - Type must be seen 0 for at least one edge before a new ack can be produced.
  - An address change with type held at 1 restarts the lookup with the same latency as a new request.
- Grant arriving in the same cycle that type drops: ignored; no RAM read is consumed.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Hit:
  - Stimulus: reset, en=1; `snoop_adr_i`=0x0000_1234, type=1; grant same cycle as REQ; RAM returns tag=0x00001, valid=1, dat=0xDEAD_BEEF.
  - Required: `snp_idx_o`=0x23, `snp_word_o`=1; ack=1, hit=1, dat=0xDEADBEEF 3 edges after request; outputs held until type=0, then all 0 one edge later.
- Miss:
  - Stimulus: same address; RAM tag=0x00002, valid=1.
  - Required: ack=1, hit=0, dat=0. With tag=0x00001, valid=0: also hit=0.
- Grant stall:
  - Stimulus: `snp_gnt_i` held 0 for 5 cycles, then 1.
  - Required: `snp_req_o`=1 for exactly 6 cycles; ack 8 edges after request.
- Disabled cache:
  - Stimulus: en=0, type=1.
  - Required: ack=1, hit=0 after 1 edge; `snp_req_o` never asserts.
- Abort and restart:
  - Stimulus (abort): type drops in WAIT. Required: no ack; IDLE.
  - Stimulus (restart): address changes to 0x0000_2238 while in DONE. Required: ack falls; new lookup with `snp_idx_o`=0x23, `snp_word_o`=2; new response.
- Reset mid-request:
  - Stimulus: `wb_rst_ni`=0 in WAIT.
  - Required: all outputs 0 next edge; returning RAM data ignored.

Source files
------------

// File: rtl/wb_snoop_responder.sv
// Snoop responder: latches a snooped read address, borrows the cache tag/data
// read port via req/gnt, and holds ack/hit/data until the arbiter withdraws.
module wb_snoop_responder #(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int index_bits  = 8,
  parameter int offset_bits = 4,
  localparam int tw         = aw - index_bits - offset_bits
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic [aw-1:0]          snoop_adr_i,
  input  logic                   snoop_type_i,
  input  logic                   snoop_en_i,
  output logic                   snoop_ack_o,
  output logic                   snoop_hit_o,
  output logic [dw-1:0]          snoop_dat_o,
  output logic                   snp_req_o,
  input  logic                   snp_gnt_i,
  output logic [index_bits-1:0]  snp_idx_o,
  output logic [offset_bits-3:0] snp_word_o,
  input  logic [tw-1:0]          tag_i,
  input  logic                   valid_i,
  input  logic [dw-1:0]          dat_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [aw-1:0]   adr_q, adr_d;
  logic            ack_q, ack_d;
  logic            hit_q, hit_d;
  logic [dw-1:0]   dat_q, dat_d;
  logic            req_q, req_d;

  logic            adr_chg;
  logic            tag_match;

  assign adr_chg   = (snoop_adr_i != adr_q);
  assign tag_match = valid_i && (tag_i == adr_q[aw-1:aw-tw]);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    ack_d   = ack_q;
    hit_d   = hit_q;
    dat_d   = dat_q;
    case (state_q)
      S_IDLE: begin
        ack_d = 1'b0;
        hit_d = 1'b0;
        dat_d = '0;
        if (snoop_type_i) begin
          adr_d = snoop_adr_i;
          if (snoop_en_i) begin
            state_d = S_REQ;
          end else begin
            // Disabled cache cannot hold the line: answer miss without a RAM read.
            state_d = S_DONE;
            ack_d   = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (!snoop_type_i) begin
          state_d = S_IDLE;
        end else if (adr_chg) begin
          adr_d = snoop_adr_i;
        end else if (snp_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!snoop_type_i) begin
          state_d = S_IDLE;
        end else if (adr_chg) begin
          // RAM data belongs to the old address; drop it and look up again.
          adr_d   = snoop_adr_i;
          state_d = S_REQ;
        end else begin
          state_d = S_DONE;
          ack_d   = 1'b1;
          hit_d   = tag_match;
          dat_d   = tag_match ? dat_i : '0;
        end
      end
      S_DONE: begin
        if (!snoop_type_i || adr_chg) begin
          ack_d   = 1'b0;
          hit_d   = 1'b0;
          dat_d   = '0;
          state_d = snoop_type_i ? S_REQ : S_IDLE;
          adr_d   = snoop_type_i ? snoop_adr_i : adr_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        ack_d   = 1'b0;
        hit_d   = 1'b0;
        dat_d   = '0;
      end
    endcase
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      ack_q   <= 1'b0;
      hit_q   <= 1'b0;
      dat_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      ack_q   <= ack_d;
      hit_q   <= hit_d;
      dat_q   <= dat_d;
      req_q   <= req_d;
    end
  end

  assign snoop_ack_o = ack_q;
  assign snoop_hit_o = hit_q;
  assign snoop_dat_o = dat_q;
  assign snp_req_o   = req_q;
  assign snp_idx_o   = adr_q[offset_bits+index_bits-1:offset_bits];
  assign snp_word_o  = adr_q[offset_bits-1:2];

endmodule

// File: tb/tb_wb_snoop_responder.sv
// Bench for wb_snoop_responder: plays the cache RAM from arrays and the
// arbiter from tasks; expected responses come from a direct array lookup.
module tb_wb_snoop_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] snoop_adr;
  logic        snoop_type, snoop_en;
  logic        ack, hit;
  logic [31:0] dat;
  logic        req, gnt;
  logic [7:0]  idx;
  logic [1:0]  word;
  logic [19:0] tag_rd;
  logic        valid_rd;
  logic [31:0] dat_rd;

  logic [19:0] mem_tag   [256];
  logic        mem_valid [256];
  logic [31:0] mem_dat   [1024];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_snoop_responder dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .snoop_adr_i (snoop_adr),
    .snoop_type_i(snoop_type),
    .snoop_en_i  (snoop_en),
    .snoop_ack_o (ack),
    .snoop_hit_o (hit),
    .snoop_dat_o (dat),
    .snp_req_o   (req),
    .snp_gnt_i   (gnt),
    .snp_idx_o   (idx),
    .snp_word_o  (word),
    .tag_i       (tag_rd),
    .valid_i     (valid_rd),
    .dat_i       (dat_rd)
  );

  // Cache RAM: one-cycle read after a granted request, junk otherwise.
  always @(posedge clk) begin
    if (req && gnt) begin
      tag_rd   <= mem_tag[idx];
      valid_rd <= mem_valid[idx];
      dat_rd   <= mem_dat[{idx, word}];
    end else begin
      tag_rd   <= 20'($urandom);
      valid_rd <= 1'($urandom);
      dat_rd   <= $urandom;
    end
  end

  function automatic void ref_lookup(input logic [31:0] a, input logic en,
                                     output logic h, output logic [31:0] d);
    logic [7:0] ix;
    ix = a[11:4];
    h  = en && mem_valid[ix] && (mem_tag[ix] == a[31:12]);
    d  = h ? mem_dat[{ix, a[3:2]}] : 32'h0;
  endfunction

  // Issue a request at a negedge and wait for ack; grant after 'stall' REQ cycles.
  task automatic do_request(input logic [31:0] a, input logic en, input int stall,
                            output int lat, output logic first_ack, output logic r_hit,
                            output logic [31:0] r_dat, output int req_cycles,
                            output logic [7:0] r_idx, output logic [1:0] r_word);
    lat = 0; first_ack = 0; r_hit = 0; r_dat = 0; req_cycles = 0; r_idx = 0; r_word = 0;
    snoop_adr = a; snoop_en = en; snoop_type = 1'b1; gnt = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) first_ack = ack;
      if (req) begin
        req_cycles++;
        r_idx  = idx;
        r_word = word;
        gnt    = (req_cycles > stall);
      end else begin
        gnt = 1'b0;
      end
      if (ack) begin
        lat = i; r_hit = hit; r_dat = dat;
        break;
      end
    end
    gnt = 1'b0;
    $display("txn adr=%08h en=%0d stall=%0d lat=%0d hit=%0d dat=%08h", a, en, stall, lat, r_hit, r_dat);
  endtask

  task automatic withdraw_and_check(input string name);
    snoop_type = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({ack, hit, dat, req} !== 35'h0) begin
      n_err++;
      $display("FAIL %s_withdraw: got ack=%0d hit=%0d dat=%08h req=%0d required all 0", name, ack, hit, dat, req);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; snoop_type = 1'b0; snoop_en = 1'b1; snoop_adr = 32'h0; gnt = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({ack, hit, dat, req, idx, word} !== 45'h0) begin
      n_err++;
      $display("FAIL reset: got ack=%0d hit=%0d dat=%08h req=%0d idx=%02h word=%0d required all 0",
               ack, hit, dat, req, idx, word);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hit;
    int lat, rc; logic fa, h; logic [31:0] d; logic [7:0] ix; logic [1:0] w;
    mem_tag[8'h23] = 20'h00001; mem_valid[8'h23] = 1'b1; mem_dat[{8'h23, 2'd1}] = 32'hDEADBEEF;
    do_request(32'h0000_1234, 1'b1, 0, lat, fa, h, d, rc, ix, w);
    n_vec++; if (ix !== 8'h23) begin n_err++; $display("FAIL hit_idx: got %02h required 23", ix); end
    n_vec++; if (w !== 2'd1) begin n_err++; $display("FAIL hit_word: got %0d required 1", w); end
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL hit_latency: got %0d required 3", lat); end
    n_vec++; if ({h, d} !== {1'b1, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL hit_resp: got hit=%0d dat=%08h required hit=1 dat=deadbeef", h, d);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if ({ack, hit, dat, req} !== {1'b1, 1'b1, 32'hDEADBEEF, 1'b0}) begin
        n_err++;
        $display("FAIL hit_hold: got ack=%0d hit=%0d dat=%08h req=%0d required 1 1 deadbeef 0", ack, hit, dat, req);
      end
    end
    withdraw_and_check("hit");
  endtask

  task automatic test_miss;
    int lat, rc; logic fa, h; logic [31:0] d; logic [7:0] ix; logic [1:0] w;
    mem_tag[8'h23] = 20'h00002; mem_valid[8'h23] = 1'b1;
    do_request(32'h0000_1234, 1'b1, 0, lat, fa, h, d, rc, ix, w);
    n_vec++; if ({lat, h, d} !== {32'd3, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL miss_tag: got lat=%0d hit=%0d dat=%08h required 3 0 0", lat, h, d);
    end
    withdraw_and_check("miss_tag");
    mem_tag[8'h23] = 20'h00001; mem_valid[8'h23] = 1'b0;
    do_request(32'h0000_1234, 1'b1, 0, lat, fa, h, d, rc, ix, w);
    n_vec++; if ({lat, h, d} !== {32'd3, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL miss_invalid: got lat=%0d hit=%0d dat=%08h required 3 0 0", lat, h, d);
    end
    withdraw_and_check("miss_invalid");
    mem_valid[8'h23] = 1'b1;
  endtask

  task automatic test_grant_stall;
    int lat, rc; logic fa, h; logic [31:0] d; logic [7:0] ix; logic [1:0] w;
    do_request(32'h0000_1234, 1'b1, 5, lat, fa, h, d, rc, ix, w);
    n_vec++; if (rc !== 6) begin n_err++; $display("FAIL stall_req_cycles: got %0d required 6", rc); end
    n_vec++; if (lat !== 8) begin n_err++; $display("FAIL stall_latency: got %0d required 8", lat); end
    n_vec++; if ({h, d} !== {1'b1, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL stall_resp: got hit=%0d dat=%08h required 1 deadbeef", h, d);
    end
    withdraw_and_check("stall");
  endtask

  task automatic test_disabled;
    int lat, rc; logic fa, h; logic [31:0] d; logic [7:0] ix; logic [1:0] w;
    do_request(32'h0000_1234, 1'b0, 0, lat, fa, h, d, rc, ix, w);
    n_vec++; if ({lat, h, d} !== {32'd1, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL disabled_resp: got lat=%0d hit=%0d dat=%08h required 1 0 0", lat, h, d);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({ack, req} !== 2'b10) begin
        n_err++; $display("FAIL disabled_hold: got ack=%0d req=%0d required ack=1 req=0", ack, req);
      end
    end
    withdraw_and_check("disabled");
    snoop_en = 1'b1;
  endtask

  task automatic test_abort;
    snoop_adr = 32'h0000_1234; snoop_en = 1'b1; snoop_type = 1'b1; gnt = 1'b0;
    @(negedge clk);
    n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL abort_req: got %0d required 1", req); end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; snoop_type = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({ack, hit, dat, req} !== 35'h0) begin
        n_err++; $display("FAIL abort_wait: got ack=%0d hit=%0d dat=%08h req=%0d required all 0", ack, hit, dat, req);
      end
    end
    // Grant in the very cycle the request is withdrawn must be ignored.
    snoop_type = 1'b1;
    @(negedge clk);
    snoop_type = 1'b0; gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({ack, req} !== 2'b00) begin
        n_err++; $display("FAIL abort_gnt_drop: got ack=%0d req=%0d required 0 0", ack, req);
      end
    end
  endtask

  task automatic test_restart;
    int lat, rc; logic fa, h, eh; logic [31:0] d, ed; logic [7:0] ix; logic [1:0] w;
    mem_tag[8'h23] = 20'h00001; mem_dat[{8'h23, 2'd2}] = 32'hCAFE_0002;
    do_request(32'h0000_1234, 1'b1, 0, lat, fa, h, d, rc, ix, w);
    n_vec++; if ({lat, h} !== {32'd3, 1'b1}) begin
      n_err++; $display("FAIL restart_first: got lat=%0d hit=%0d required 3 1", lat, h);
    end
    mem_tag[8'h23] = 20'h00002;
    ref_lookup(32'h0000_2238, 1'b1, eh, ed);
    do_request(32'h0000_2238, 1'b1, 0, lat, fa, h, d, rc, ix, w);
    n_vec++; if (fa !== 1'b0) begin n_err++; $display("FAIL restart_ack_fall: got %0d required 0", fa); end
    n_vec++; if ({ix, w} !== {8'h23, 2'd2}) begin
      n_err++; $display("FAIL restart_idx_word: got %02h/%0d required 23/2", ix, w);
    end
    n_vec++; if ({lat, h, d} !== {32'd3, eh, ed}) begin
      n_err++; $display("FAIL restart_resp: got lat=%0d hit=%0d dat=%08h required 3 %0d %08h", lat, h, d, eh, ed);
    end
    withdraw_and_check("restart");
  endtask

  task automatic test_reset_mid;
    snoop_adr = 32'h0000_1234; snoop_en = 1'b1; snoop_type = 1'b1; gnt = 1'b0;
    @(negedge clk);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; rst_n = 1'b0; snoop_type = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({ack, hit, dat, req, idx} !== 43'h0) begin
      n_err++; $display("FAIL reset_mid: got ack=%0d hit=%0d dat=%08h req=%0d idx=%02h required all 0",
                        ack, hit, dat, req, idx);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({ack, req} !== 2'b00) begin
        n_err++; $display("FAIL reset_mid_after: got ack=%0d req=%0d required 0 0", ack, req);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, rc; logic fa, h, eh; logic [31:0] d, ed, a; logic [7:0] ix; logic [1:0] w;
    for (int k = 0; k < 3; k++) begin
      a = {mem_tag[8'h40 + 8'(k)], 8'h40 + 8'(k), 2'(k), 2'b00};
      mem_valid[8'h40 + 8'(k)] = 1'b1;
      ref_lookup(a, 1'b1, eh, ed);
      do_request(a, 1'b1, 0, lat, fa, h, d, rc, ix, w);
      n_vec++; if ({lat, h, d} !== {32'd3, eh, ed}) begin
        n_err++; $display("FAIL b2b_%0d: got lat=%0d hit=%0d dat=%08h required 3 %0d %08h", k, lat, h, d, eh, ed);
      end
      withdraw_and_check("b2b");
    end
  endtask

  task automatic test_random;
    int lat, rc, stall, exp_lat, exp_rc; logic fa, h, eh, en; logic [31:0] d, ed, a;
    logic [7:0] ix, ri; logic [1:0] w, rw; logic [19:0] t;
    for (int k = 0; k < 40; k++) begin
      ri = 8'($urandom_range(0, 255));
      rw = 2'($urandom_range(0, 3));
      t  = ($urandom_range(0, 1) == 1) ? mem_tag[ri] : 20'($urandom);
      a  = {t, ri, rw, 2'($urandom)};
      en = ($urandom_range(0, 4) != 0);
      stall = $urandom_range(0, 3);
      ref_lookup(a, en, eh, ed);
      exp_lat = en ? 3 + stall : 1;
      exp_rc  = en ? stall + 1 : 0;
      do_request(a, en, stall, lat, fa, h, d, rc, ix, w);
      n_vec++;
      if ({lat, rc, h, d} !== {exp_lat, exp_rc, eh, ed}) begin
        n_err++; $display("FAIL rand_%0d: got lat=%0d req=%0d hit=%0d dat=%08h required %0d %0d %0d %08h",
                          k, lat, rc, h, d, exp_lat, exp_rc, eh, ed);
      end
      if (en) begin
        n_vec++;
        if ({ix, w} !== {ri, rw}) begin
          n_err++; $display("FAIL rand_idx_%0d: got %02h/%0d required %02h/%0d", k, ix, w, ri, rw);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        a = a ^ 32'h0000_1000;
        ref_lookup(a, 1'b1, eh, ed);
        do_request(a, 1'b1, 0, lat, fa, h, d, rc, ix, w);
        n_vec++;
        if ({fa, lat, h, d} !== {1'b0, 32'd3, eh, ed}) begin
          n_err++; $display("FAIL rand_restart_%0d: got ack1=%0d lat=%0d hit=%0d dat=%08h required 0 3 %0d %08h",
                            k, fa, lat, h, d, eh, ed);
        end
      end
      withdraw_and_check("rand");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_tag[i]   = 20'($urandom);
      mem_valid[i] = 1'($urandom);
    end
    for (int i = 0; i < 1024; i++) mem_dat[i] = $urandom;
    test_reset();
    test_hit();
    test_miss();
    test_grant_stall();
    test_disabled();
    test_abort();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
